// File: rtl/ahb_req_scheduler.sv
// Two-requester round-robin front end for a single AHB-Lite master.
// Sequences the granted command as NONSEQ then SEQ beats and returns read data after RD_LAT.
module ahb_req_scheduler #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             m0_req,
    input  logic [31:0]      m0_addr,
    input  logic             m0_write,
    input  logic [2:0]       m0_size,
    input  logic [LEN_W-1:0] m0_len,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_wack,
    output logic             m0_rvalid,
    output logic             m0_done,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic [31:0]      m1_addr,
    input  logic             m1_write,
    input  logic [2:0]       m1_size,
    input  logic [LEN_W-1:0] m1_len,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_wack,
    output logic             m1_rvalid,
    output logic             m1_done,
    output logic             m1_err,
    output logic [31:0]      rdata,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic [31:0]      HRDATA,
    output logic [31:0]      PADDR,
    output logic [31:0]      PWDATA,
    output logic             PWRITE,
    output logic [2:0]       PSIZE,
    output logic [1:0]       PTRANS,
    output logic [2:0]       PBURST
);

    typedef enum logic [1:0] {StIdle, StNonseq, StSeq, StDone} state_e;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [31:0]      base_q, base_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             err_q, err_d;

    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_own_q, pipe_own_d;
    logic              rvalid_q, rv_own_q;
    logic [31:0]       rdata_q;

    logic             sel;
    logic [LEN_W-1:0] req_len, clamp_len;
    logic             active, accept, last_beat, in_cmd;

    // Both requesting: rr picks; otherwise whoever is requesting.
    always_comb begin
        sel = 1'b0;
        if (m0_req && m1_req) begin
            sel = rr_q;
        end else if (!m0_req) begin
            sel = 1'b1;
        end
        req_len = sel ? m1_len : m0_len;
        if (req_len == '0) begin
            clamp_len = LEN_W'(1);
        end else if (req_len > MaxLen) begin
            clamp_len = MaxLen;
        end else begin
            clamp_len = req_len;
        end
    end

    assign active    = (state_q == StNonseq) || (state_q == StSeq);
    assign in_cmd    = active || (state_q == StDone);
    assign accept    = active && HREADY;
    assign last_beat = (beat_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        base_d  = base_q;
        write_d = write_q;
        size_d  = size_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = sel;
                    base_d  = sel ? m1_addr : m0_addr;
                    write_d = sel ? m1_write : m0_write;
                    size_d  = sel ? m1_size : m0_size;
                    len_d   = clamp_len;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = StNonseq;
                end
            end
            StNonseq, StSeq: begin
                if (HREADY) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (HRESP) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (last_beat) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSeq;
                    end
                end
            end
            StDone: begin
                rr_d    = ~owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read-latency pipe: tracks which owner each accepted read beat belongs to.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_own_d    = pipe_own_q;
        pipe_vld_d[0] = accept && !write_q;
        pipe_own_d[0] = owner_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_own_d[i] = pipe_own_q[i-1];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            base_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            pipe_vld_q <= '0;
            pipe_own_q <= '0;
            rvalid_q   <= 1'b0;
            rv_own_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            write_q    <= write_d;
            size_q     <= size_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_own_q <= pipe_own_d;
            rvalid_q   <= pipe_vld_q[RD_LAT-1];
            rv_own_q   <= pipe_own_q[RD_LAT-1];
            if (pipe_vld_q[RD_LAT-1]) begin
                rdata_q <= HRDATA;
            end
        end
    end

    assign PTRANS = (state_q == StNonseq) ? 2'b10 : (state_q == StSeq) ? 2'b11 : 2'b00;
    assign PADDR  = active ? base_q + (32'(beat_q) << size_q) : '0;
    assign PWDATA = active ? (owner_q ? m1_wdata : m0_wdata) : '0;
    assign PWRITE = write_q;
    assign PSIZE  = size_q;
    assign PBURST = (in_cmd && len_q != LEN_W'(1)) ? 3'b001 : 3'b000;

    assign m0_gnt    = active && !owner_q;
    assign m1_gnt    = active && owner_q;
    assign m0_wack   = accept && !owner_q;
    assign m1_wack   = accept && owner_q;
    assign m0_done   = (state_q == StDone) && !owner_q;
    assign m1_done   = (state_q == StDone) && owner_q;
    assign m0_err    = m0_done && err_q;
    assign m1_err    = m1_done && err_q;
    assign m0_rvalid = rvalid_q && !rv_own_q;
    assign m1_rvalid = rvalid_q && rv_own_q;
    assign rdata     = rdata_q;

endmodule
